// File: rtl/bitmap_addr_arb.sv
// rtl/bitmap_addr_arb.sv - two-requester round-robin front end for a bitmap address pipeline
// Tags each accepted x/y with its requester id and re-attaches it to the returned addr/clip.
module bitmap_addr_arb #(
   parameter int CORDW     = 16,
   parameter int ADDRW     = 24,
   parameter int LAT       = 3,
   parameter int DROP_CLIP = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [CORDW-1:0] req_x0,
   input  logic [CORDW-1:0] req_y0,
   input  logic [CORDW-1:0] req_x1,
   input  logic [CORDW-1:0] req_y1,
   output logic [CORDW-1:0] bmp_x,
   output logic [CORDW-1:0] bmp_y,
   input  logic [ADDRW-1:0] bmp_addr,
   input  logic             bmp_clip,
   output logic             out_valid,
   output logic             out_id,
   output logic [ADDRW-1:0] out_addr,
   output logic             out_clip,
   output logic             busy,
   output logic [15:0]      clip_cnt
);

   localparam logic W_DROP = (DROP_CLIP != 0);

   logic             r_last;
   logic [CORDW-1:0] r_bmp_x;
   logic [CORDW-1:0] r_bmp_y;
   logic [LAT:0]     r_dv;
   logic [LAT:0]     r_did;
   logic [15:0]      r_clip_cnt;

   logic [1:0]       w_grant;
   logic             w_hs;
   logic             w_gid;
   logic             w_retire_clip;

   // Both valid: serve whoever was not served last; r_last resets to 1 so requester 0 wins first.
   always_comb begin
      w_grant = 2'b00;
      if (!rst) begin
         case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
         endcase
      end
   end

   assign w_hs          = |w_grant;
   assign w_gid         = w_grant[1];
   assign w_retire_clip = r_dv[LAT] & bmp_clip;

   // Stage LAT lines up with the cycle after the pipeline's LAT-th edge, i.e. the result cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last     <= 1'b1;
         r_bmp_x    <= '0;
         r_bmp_y    <= '0;
         r_dv       <= '0;
         r_did      <= '0;
         r_clip_cnt <= '0;
      end else begin
         if (w_hs) begin
            r_last  <= w_gid;
            r_bmp_x <= w_gid ? req_x1 : req_x0;
            r_bmp_y <= w_gid ? req_y1 : req_y0;
         end
         r_dv  <= {r_dv[LAT-1:0], w_hs};
         r_did <= {r_did[LAT-1:0], w_gid};
         if (w_retire_clip && (r_clip_cnt != 16'hFFFF)) begin
            r_clip_cnt <= r_clip_cnt + 16'd1;
         end
      end
   end

   assign req_ready = w_grant;
   assign bmp_x     = r_bmp_x;
   assign bmp_y     = r_bmp_y;
   assign out_valid = r_dv[LAT] & ~(W_DROP & bmp_clip);
   assign out_id    = r_did[LAT];
   assign out_addr  = bmp_addr;
   assign out_clip  = bmp_clip;
   assign busy      = |r_dv;
   assign clip_cnt  = r_clip_cnt;

endmodule
